// File: rtl/monitor_contador_if.sv
// Bundle of the sample-stream inputs and the monitor result outputs of
// monitor_contador. The master side drives samples and acknowledges errors;
// the slave side (the monitor) reports wraps, sequence errors and FSM state.
interface monitor_contador_if #(
    parameter int WRAP_W = 8,
    parameter int ERR_W  = 4
);
    logic [2:0]        cnt_in;
    logic              cnt_vld;
    logic              enable;
    logic              err_ack;
    logic [WRAP_W-1:0] wraps;
    logic              wrap_pulse;
    logic              wrap_ovf;
    logic              seq_err;
    logic              err_sticky;
    logic [ERR_W-1:0]  err_count;
    logic [1:0]        state;

    modport master (
        output cnt_in, cnt_vld, enable, err_ack,
        input  wraps, wrap_pulse, wrap_ovf, seq_err, err_sticky, err_count, state
    );

    modport slave (
        input  cnt_in, cnt_vld, enable, err_ack,
        output wraps, wrap_pulse, wrap_ovf, seq_err, err_sticky, err_count, state
    );
endinterface

// File: rtl/monitor_contador.sv
// Monitor for an upstream mod-8 counter. Checks that every accepted sample is
// the previous one plus one (mod 8), counts 7->0 wraps, flags the first bad
// sample of each error burst and keeps a saturating count of bursts.
module monitor_contador #(
    parameter int WRAP_W = 8,
    parameter int ERR_W  = 4
) (
    input  logic               clk,
    input  logic               clr,
    monitor_contador_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        TRACK = 2'b01,
        ERROR = 2'b10,
        BAD   = 2'b11
    } state_t;

    state_t            r_state;
    logic [2:0]        r_prev;
    logic [WRAP_W-1:0] r_wraps;
    logic              r_wrap_pulse;
    logic              r_wrap_ovf;
    logic              r_seq_err;
    logic              r_err_sticky;
    logic [ERR_W-1:0]  r_err_count;

    logic              w_accept;
    logic [2:0]        w_expected;
    logic              w_match;
    logic              w_is_wrap;

    // A sample counts only when it is both valid and enabled.
    assign w_accept   = bus.cnt_vld & bus.enable;
    assign w_expected = r_prev + 3'd1;
    assign w_match    = (bus.cnt_in == w_expected);
    // A matching sample after prev=7 is necessarily a 7->0 step.
    assign w_is_wrap  = (r_prev == 3'd7);

    // Sequence-tracking FSM together with all counters and flags it drives.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state      <= IDLE;
            r_prev       <= 3'd0;
            r_wraps      <= '0;
            r_wrap_pulse <= 1'b0;
            r_wrap_ovf   <= 1'b0;
            r_seq_err    <= 1'b0;
            r_err_sticky <= 1'b0;
            r_err_count  <= '0;
        end else begin
            // Pulses last exactly one cycle unless re-armed below.
            r_wrap_pulse <= 1'b0;
            r_seq_err    <= 1'b0;

            // Acknowledge works regardless of enable; a new error written
            // later in this block overrides it.
            if (bus.err_ack) begin
                r_err_sticky <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_prev  <= bus.cnt_in;
                        r_state <= TRACK;
                    end
                end
                TRACK: begin
                    if (w_accept) begin
                        r_prev <= bus.cnt_in;
                        if (w_match) begin
                            if (w_is_wrap) begin
                                r_wrap_pulse <= 1'b1;
                                r_wraps      <= r_wraps + WRAP_W'(1);
                                if (r_wraps == {WRAP_W{1'b1}}) begin
                                    r_wrap_ovf <= 1'b1;
                                end
                            end
                        end else begin
                            r_seq_err    <= 1'b1;
                            r_err_sticky <= 1'b1;
                            if (r_err_count != {ERR_W{1'b1}}) begin
                                r_err_count <= r_err_count + ERR_W'(1);
                            end
                            r_state <= ERROR;
                        end
                    end
                end
                ERROR: begin
                    // Resync on every sample; a match closes the burst
                    // silently, even when it is a 7->0 step.
                    if (w_accept) begin
                        r_prev <= bus.cnt_in;
                        if (w_match) begin
                            r_state <= TRACK;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.wraps      = r_wraps;
    assign bus.wrap_pulse = r_wrap_pulse;
    assign bus.wrap_ovf   = r_wrap_ovf;
    assign bus.seq_err    = r_seq_err;
    assign bus.err_sticky = r_err_sticky;
    assign bus.err_count  = r_err_count;
    assign bus.state      = r_state;

endmodule

// File: tb/tb_monitor_contador.sv
// Scoreboard bench for monitor_contador: instance A uses default widths,
// instance B uses WRAP_W=2 / ERR_W=2 for rollover and saturation.
module tb_monitor_contador;

    logic clk;
    logic clr_a;
    logic clr_b;

    monitor_contador_if #(.WRAP_W(8), .ERR_W(4)) bus_a ();
    monitor_contador_if #(.WRAP_W(2), .ERR_W(2)) bus_b ();

    monitor_contador #(.WRAP_W(8), .ERR_W(4)) u_dut_a (
        .clk (clk),
        .clr (clr_a),
        .bus (bus_a)
    );

    monitor_contador #(.WRAP_W(2), .ERR_W(2)) u_dut_b (
        .clk (clk),
        .clr (clr_b),
        .bus (bus_b)
    );

    // Expected output vector layout: {wraps[7:0], wrap_pulse, wrap_ovf,
    // seq_err, err_sticky, err_count[3:0], state[1:0]}
    typedef struct {
        bit          dut;
        logic [17:0] exp;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [17:0] act(input bit d);
        if (d == 1'b0) begin
            return {bus_a.wraps, bus_a.wrap_pulse, bus_a.wrap_ovf, bus_a.seq_err,
                    bus_a.err_sticky, bus_a.err_count, bus_a.state};
        end else begin
            return {6'd0, bus_b.wraps, bus_b.wrap_pulse, bus_b.wrap_ovf, bus_b.seq_err,
                    bus_b.err_sticky, 2'b00, bus_b.err_count, bus_b.state};
        end
    endfunction

    task automatic check(input string name, input logic [17:0] a, input logic [17:0] e);
        n_checks++;
        if (a !== e) begin
            n_errors++;
            $display("FAIL %s: got wraps=%0d wp=%b ovf=%b se=%b st=%b ec=%0d state=%b, expected wraps=%0d wp=%b ovf=%b se=%b st=%b ec=%0d state=%b",
                     name, a[17:10], a[9], a[8], a[7], a[6], a[5:2], a[1:0],
                     e[17:10], e[9], e[8], e[7], e[6], e[5:2], e[1:0]);
        end
    endtask

    // Drive one cycle of stimulus into the selected DUT and queue the
    // outputs expected after the following rising edge.
    task automatic step(input bit d, input logic [2:0] c, input bit v, input bit en,
                        input bit ack, input logic [7:0] ew, input bit ewp, input bit eov,
                        input bit ese, input bit est, input logic [3:0] ec,
                        input logic [1:0] es);
        exp_t x;
        @(negedge clk);
        bus_a.cnt_vld = 1'b0;
        bus_a.err_ack = 1'b0;
        bus_b.cnt_vld = 1'b0;
        bus_b.err_ack = 1'b0;
        if (d == 1'b0) begin
            bus_a.cnt_in  = c;
            bus_a.cnt_vld = v;
            bus_a.enable  = en;
            bus_a.err_ack = ack;
        end else begin
            bus_b.cnt_in  = c;
            bus_b.cnt_vld = v;
            bus_b.enable  = en;
            bus_b.err_ack = ack;
        end
        x.dut = d;
        x.exp = {ew, ewp, eov, ese, est, ec, es};
        q.push_back(x);
    endtask

    task automatic idle();
        @(negedge clk);
        bus_a.cnt_vld = 1'b0;
        bus_a.err_ack = 1'b0;
        bus_b.cnt_vld = 1'b0;
        bus_b.err_ack = 1'b0;
    endtask

    // Monitor: after each rising edge, compare any pending expectation.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                x = q.pop_front();
                check(x.dut ? "sb_b" : "sb_a", act(x.dut), x.exp);
            end
        end
    end

    initial begin
        logic [7:0] ew;
        logic [3:0] ec;
        clr_a = 1'b0;
        clr_b = 1'b0;
        bus_a.cnt_in = 3'd0; bus_a.cnt_vld = 1'b0; bus_a.enable = 1'b1; bus_a.err_ack = 1'b0;
        bus_b.cnt_in = 3'd0; bus_b.cnt_vld = 1'b0; bus_b.enable = 1'b1; bus_b.err_ack = 1'b0;
        #1;
        clr_a = 1'b1;
        clr_b = 1'b1;
        #1;
        check("reset_a", act(1'b0), 18'd0);
        check("reset_b", act(1'b1), 18'd0);
        @(negedge clk);
        clr_a = 1'b0;
        clr_b = 1'b0;

        // Clean run through a wrap: 5,6,7,0,1
        step(0, 3'd5, 1, 1, 0, 8'd0, 0, 0, 0, 0, 4'd0, 2'b01);
        step(0, 3'd6, 1, 1, 0, 8'd0, 0, 0, 0, 0, 4'd0, 2'b01);
        step(0, 3'd7, 1, 1, 0, 8'd0, 0, 0, 0, 0, 4'd0, 2'b01);
        step(0, 3'd0, 1, 1, 0, 8'd1, 1, 0, 0, 0, 4'd0, 2'b01);
        step(0, 3'd1, 1, 1, 0, 8'd1, 0, 0, 0, 0, 4'd0, 2'b01);
        // Skip: 2,3,5,6,7
        step(0, 3'd2, 1, 1, 0, 8'd1, 0, 0, 0, 0, 4'd0, 2'b01);
        step(0, 3'd3, 1, 1, 0, 8'd1, 0, 0, 0, 0, 4'd0, 2'b01);
        step(0, 3'd5, 1, 1, 0, 8'd1, 0, 0, 1, 1, 4'd1, 2'b10);
        step(0, 3'd6, 1, 1, 0, 8'd1, 0, 0, 0, 1, 4'd1, 2'b01);
        step(0, 3'd7, 1, 1, 0, 8'd1, 0, 0, 0, 1, 4'd1, 2'b01);

        // Synchronous-style clear pulse between scenarios
        @(negedge clk);
        bus_a.cnt_vld = 1'b0;
        clr_a = 1'b1;
        #1;
        check("clr_pulse_a", act(1'b0), 18'd0);
        @(negedge clk);
        clr_a = 1'b0;

        // Repeats: 1,1,1,2 then acknowledge with enable low
        step(0, 3'd1, 1, 1, 0, 8'd0, 0, 0, 0, 0, 4'd0, 2'b01);
        step(0, 3'd1, 1, 1, 0, 8'd0, 0, 0, 1, 1, 4'd1, 2'b10);
        step(0, 3'd1, 1, 1, 0, 8'd0, 0, 0, 0, 1, 4'd1, 2'b10);
        step(0, 3'd2, 1, 1, 0, 8'd0, 0, 0, 0, 1, 4'd1, 2'b01);
        step(0, 3'd0, 0, 0, 1, 8'd0, 0, 0, 0, 0, 4'd1, 2'b01);
        // Enable low holds prev: the bad sample is ignored, then 3 matches
        step(0, 3'd5, 1, 0, 0, 8'd0, 0, 0, 0, 0, 4'd1, 2'b01);
        step(0, 3'd3, 1, 1, 0, 8'd0, 0, 0, 0, 0, 4'd1, 2'b01);
        idle();

        // Asynchronous clear between edges while tracking
        @(posedge clk);
        #3;
        clr_a = 1'b1;
        #1;
        check("async_clr_a", act(1'b0), 18'd0);
        @(negedge clk);
        bus_a.cnt_in  = 3'd6;
        bus_a.cnt_vld = 1'b1;
        bus_a.enable  = 1'b1;
        @(negedge clk);
        check("clr_no_accept_a", act(1'b0), 18'd0);
        bus_a.cnt_vld = 1'b0;
        clr_a = 1'b0;
        step(0, 3'd4, 1, 1, 0, 8'd0, 0, 0, 0, 0, 4'd0, 2'b01);
        step(0, 3'd5, 1, 1, 0, 8'd0, 0, 0, 0, 0, 4'd0, 2'b01);
        // 7->0 closing an error burst is not a wrap
        step(0, 3'd7, 1, 1, 0, 8'd0, 0, 0, 1, 1, 4'd1, 2'b10);
        step(0, 3'd0, 1, 1, 0, 8'd0, 0, 0, 0, 1, 4'd1, 2'b01);
        idle();

        // Instance B: 0..7 four times plus a closing 0 -> wraps 1,2,3,0
        for (int i = 0; i < 33; i++) begin
            ew = 8'((i / 8) % 4);
            step(1, 3'(i % 8), 1, 1, 0, ew, (i % 8 == 0) && (i > 0), (i >= 32),
                 0, 0, 4'd0, 2'b01);
        end
        // Five error bursts; the fifth error coincides with err_ack
        for (int k = 1; k <= 5; k++) begin
            ec = 4'((k < 3) ? k : 3);
            step(1, 3'd2, 1, 1, (k == 5), 8'd0, 0, 1, 1, 1, ec, 2'b10);
            step(1, 3'd3, 1, 1, (k < 5), 8'd0, 0, 1, 0, (k == 5), ec, 2'b01);
        end
        step(1, 3'd0, 0, 1, 1, 8'd0, 0, 1, 0, 0, 4'd3, 2'b01);
        idle();

        for (int i = 0; i < 20 && q.size() > 0; i++) begin
            @(posedge clk);
        end
        #5;
        if (q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/monitor_contador.md
MONITOR_CONTADOR -- requirements
Module: monitor_contador

Interface
REQ-001 The parameter WRAP_W SHALL default to 8 and SHALL set the width of the wrap counter.
REQ-002 The parameter ERR_W SHALL default to 4 and SHALL set the width of the saturating error counter.
REQ-003 Port clk SHALL be an input, 1 bit wide, and SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Port clr SHALL be an input, 1 bit wide, and SHALL be an asynchronous, active-high reset.
REQ-005 Port cnt_in SHALL be an input, 3 bits wide, carrying the count value from the upstream mod-8 counter.
REQ-006 Port cnt_vld SHALL be an input, 1 bit wide; when high, cnt_in holds a new count sample this cycle.
REQ-007 Port enable SHALL be an input, 1 bit wide; when low, samples are ignored and all state is held.
REQ-008 Port err_ack SHALL be an input, 1 bit wide, and SHALL clear err_sticky.
REQ-009 Port wraps SHALL be an output, WRAP_W bits wide, giving the number of 7->0 wraps seen.
REQ-010 Port wrap_pulse SHALL be an output, 1 bit wide, high for one cycle per wrap.
REQ-011 Port wrap_ovf SHALL be an output, 1 bit wide, and SHALL be a sticky flag that wraps has rolled over.
REQ-012 Port seq_err SHALL be an output, 1 bit wide, high for one cycle on the first bad sample of an error burst.
REQ-013 Port err_sticky SHALL be an output, 1 bit wide, latched high on error until acknowledged.
REQ-014 Port err_count SHALL be an output, ERR_W bits wide, holding the number of error bursts, saturating.
REQ-015 Port state SHALL be an output, 2 bits wide, giving the FSM state: IDLE=00, TRACK=01, ERROR=10.

Function
REQ-016 A sample SHALL be accepted only on a rising clk edge with cnt_vld=1 and enable=1; all outputs SHALL be registered, with responses visible 1 cycle after the accepting edge.
REQ-017 Every accepted sample SHALL be stored in an internal 3-bit prev register; expected SHALL equal (prev+1) mod 8.
REQ-018 In IDLE, the first accepted sample SHALL load prev, SHALL perform no check, and SHALL move the FSM to TRACK.
REQ-019 In TRACK, a sample equal to expected SHALL keep the FSM in TRACK; if prev=7 and the sample is 0, the block SHALL pulse wrap_pulse and increment wraps.
REQ-020 In TRACK, a sample not equal to expected (including a repeated value) SHALL pulse seq_err, set err_sticky, increment err_count, and move the FSM to ERROR.
REQ-021 In ERROR, each accepted sample SHALL resync prev; a sample equal to expected SHALL return the FSM to TRACK and produce no pulse; a mismatch SHALL stay in ERROR with no seq_err pulse and no change to err_count.
REQ-022 A 7->0 transition that closes an ERROR burst SHALL NOT count as a wrap.
REQ-023 wraps SHALL wrap from 2^WRAP_W-1 to 0; on that rollover the block SHALL set wrap_ovf, which stays set until reset.
REQ-024 err_count SHALL saturate at 2^ERR_W-1.
REQ-025 err_ack SHALL clear err_sticky in any state, with or without enable; err_count SHALL be unaffected by err_ack.
REQ-026 When err_ack and a new TRACK error occur in the same cycle, the error SHALL win and err_sticky SHALL remain 1.
REQ-027 With enable=0, cnt_vld SHALL be ignored, and the state, prev, and counters SHALL be held; the pulse outputs SHALL be 0.
REQ-028 The FSM SHALL never enter the unused state encoding 11; if it does, it SHALL go to IDLE on the next edge.

Reset
REQ-029 clr=1 SHALL immediately, without waiting for clk, force: state=IDLE, prev=0, wraps=0, wrap_pulse=0, wrap_ovf=0, seq_err=0, err_sticky=0, err_count=0.
REQ-030 An assertion of clr mid-sequence SHALL discard prev, so that the first sample after release is unchecked (IDLE behaviour).
REQ-031 Deassertion of clr SHALL take effect at the next rising clk edge; there SHALL be no samples accepted while clr=1.

Verification
REQ-032 The bench SHALL cover: clr pulse, then samples 5,6,7,0,1 with vld=1 and enable=1 -> state 00->01, one wrap_pulse after the 0, wraps=1, seq_err never asserted.
REQ-033 The bench SHALL cover: samples 2,3,5,6,7 -> one seq_err after the 5, err_count=1, err_sticky=1, state=10 then back to 01 on the 6.
REQ-034 The bench SHALL cover: samples 1,1,1,2 -> one seq_err only, err_count=1, return to TRACK on the 2; then err_ack=1 -> err_sticky=0, err_count still 1.
REQ-035 The bench SHALL cover: WRAP_W=2, feeding 0..7 four times continuously -> wraps 1,2,3,0, wrap_ovf=1 after the fourth wrap.
REQ-036 The bench SHALL cover: ERR_W=2 and 5 separate error bursts -> err_count stops at 3; err_ack coinciding with the 5th error -> err_sticky=1.
REQ-037 The bench SHALL cover: asserting clr asynchronously between edges during TRACK -> all outputs 0 before the next edge; then sample 4 with no check, then 5 with no error.
